regfile_scoreboard: RTL

Parametrised successor to the LITE-16 register file. It provides three registered read ports (A, B, C), one write port with same-cycle write-to-read bypass, optional hardwired-zero R0, and a per-register pending scoreboard. The scoreboard flags read-after-write hazards for multi-cycle producers. The block sits between decode and execute: decode issues reads and destination reservations, and writeback drives the write port.

---
 rtl/regfile_scoreboard.sv | 126 ++++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// ------------------
// Register file with three registered read ports, one write port with
// same-cycle write-to-read bypass, an optional hardwired-zero register 0,
// and a per-register pending scoreboard. The scoreboard flags
// read-after-write hazards against multi-cycle producers.
//
// Ports
//   clk                      rising-edge clock
//   rst                      asynchronous active-low reset
//   rd_valid                 read request this cycle
//   ra_addr/rb_addr/rc_addr  read addresses, ports A/B/C
//   ra_data/rb_data/rc_data  registered read data (held while rd_valid=0)
//   rd_hazard                registered; some requested source was pending
//   rsv_en/rsv_addr          reserve (mark pending) a destination register
//   wr_en/wr_addr/wr_data    writeback port; clears the pending bit
//   busy                     pending vector, straight from the flops
//
// Read handshake: there is no back-pressure. A read is accepted on every
// rising edge where rd_valid=1. Its data and hazard flag appear after that
// edge and stay stable until the next edge with rd_valid=1. On an edge with
// rd_valid=0 the data holds and rd_hazard drops to 0.

module regfile_scoreboard #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter bit R0_ZERO = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_valid,
    input  logic [ADDR_W-1:0]       ra_addr,
    input  logic [ADDR_W-1:0]       rb_addr,
    input  logic [ADDR_W-1:0]       rc_addr,
    output logic [DATA_W-1:0]       ra_data,
    output logic [DATA_W-1:0]       rb_data,
    output logic [DATA_W-1:0]       rc_data,
    output logic                    rd_hazard,
    input  logic                    rsv_en,
    input  logic [ADDR_W-1:0]       rsv_addr,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [(1<<ADDR_W)-1:0]  busy
);

    localparam int REGS  = 1 << ADDR_W;
    localparam int NPORT = 3;

    logic [DATA_W-1:0] regs_q  [REGS];
    logic [DATA_W-1:0] regs_d  [REGS];
    logic [REGS-1:0]   pend_q;
    logic [REGS-1:0]   pend_d;
    logic [DATA_W-1:0] rdata_q [NPORT];
    logic [DATA_W-1:0] rdata_d [NPORT];
    logic              hazard_q;
    logic              hazard_d;
    logic [ADDR_W-1:0] raddr   [NPORT];
    logic              wr_ok;
    logic              rsv_ok;

    assign raddr[0] = ra_addr;
    assign raddr[1] = rb_addr;
    assign raddr[2] = rc_addr;

    // With a hardwired R0, writes and reserves aimed at it are dropped
    // here so neither storage nor the pending bit ever changes for r0.
    assign wr_ok  = wr_en  && !(R0_ZERO && (wr_addr  == '0));
    assign rsv_ok = rsv_en && !(R0_ZERO && (rsv_addr == '0));

    // Storage and scoreboard next state. The reserve is applied after the
    // write so that a same-address write+reserve leaves the register
    // pending: the newly issued producer owns it.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
            pend_d[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            pend_d[rsv_addr] = 1'b1;
        end
    end

    // Read ports. Reads see pre-edge scoreboard state, so a same-cycle
    // reserve never raises a hazard, while a same-cycle write both
    // forwards its data and clears the hazard for that port.
    always_comb begin
        rdata_d  = rdata_q;
        hazard_d = 1'b0;
        if (rd_valid) begin
            for (int p = 0; p < NPORT; p++) begin
                if (R0_ZERO && (raddr[p] == '0)) begin
                    rdata_d[p] = '0;
                end else if (wr_ok && (wr_addr == raddr[p])) begin
                    rdata_d[p] = wr_data;
                end else begin
                    rdata_d[p] = regs_q[raddr[p]];
                    hazard_d   = hazard_d | pend_q[raddr[p]];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q   <= '{default: '0};
            pend_q   <= '0;
            rdata_q  <= '{default: '0};
            hazard_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            pend_q   <= pend_d;
            rdata_q  <= rdata_d;
            hazard_q <= hazard_d;
        end
    end

    assign ra_data   = rdata_q[0];
    assign rb_data   = rdata_q[1];
    assign rc_data   = rdata_q[2];
    assign rd_hazard = hazard_q;
    assign busy      = pend_q;

endmodule
